random_range_gen: RTL and testbench
===================================

# random_range_gen

Parametrised random-value generator for the reaction-timer datapath. It produces values in the closed range [MIN_VALUE, MAX_VALUE] on request and has two sources: a wrapping counter that follows the user's press timing, and a free-running Galois LFSR that can be reseeded. LFSR samples are folded into range by a bounded multi-cycle subtract loop, so there is no divider. It sits between the game FSM, which issues `Req` and waits for `Valid`, and the delay counter, which consumes `RandomValue`.

## Interface
- WIDTH, 13: output width; MAX_VALUE < 2^WIDTH required.
- MIN_VALUE, 1000: lowest output value.
- MAX_VALUE, 6000: highest output value; MAX_VALUE ≥ MIN_VALUE required.
- LFSR_W, 16: LFSR register width.
- TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1: reset seed, also substituted for a zero seed.
- RAND_W, 13: low LFSR bits sampled per request; 2^RAND_W ≤ 16·(SPAN+1) required, where SPAN = MAX_VALUE−MIN_VALUE.
- Clk  in  1  clock, all logic on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Mode  in  1  source select, sampled with Req: 0 = counter, 1 = LFSR.
- Req  in  1  request pulse; ignored while Busy=1.
- SeedLoad  in  1  load Seed into the LFSR this edge.
- Seed  in  LFSR_W  new seed value.
- Busy  out  1  LFSR reduction in progress.
- Valid  out  1  RandomValue holds a completed result.
- RandomValue  out  WIDTH  last generated value.

## Operation
- **Counter `Cnt`** (WIDTH bits): increments every cycle. At MAX_VALUE it wraps to MIN_VALUE.
- **LFSR `L`**: advances every cycle regardless of Req.
  - L <= L[0] ? (L>>1)^TAPS : L>>1.
  - SeedLoad=1 loads Seed instead of advancing; Seed==0 loads SEED, so the all-zero lockup is impossible.
- **FSM states**: IDLE, REDUCE.
- **IDLE, Req=1, Mode=0**:
  - RandomValue <= Cnt (the pre-edge value).
  - Valid <= 1; state stays IDLE.
- **IDLE, Req=1, Mode=1**:
  - R <= L[RAND_W-1:0] (pre-edge L).
  - Valid <= 0, Busy <= 1 → REDUCE.
- **REDUCE**:
  - If R > SPAN: R <= R−(SPAN+1) and stay in REDUCE.
  - Otherwise: RandomValue <= MIN_VALUE+R (WIDTH-bit add, cannot overflow), Valid <= 1, Busy <= 0 → IDLE.
- **Result distribution**: the result equals MIN_VALUE + (raw mod (SPAN+1)).
- **Valid/RandomValue hold**: both hold until the next accepted Req.
- **Req and Busy**: Req while Busy=1 is dropped; it is not queued.
- **Mode changes**: Mode changes during REDUCE have no effect on the result in progress.
- **SeedLoad with Req, same edge**: the sample uses the pre-load L, and the seed load still takes effect.
- **SeedLoad during REDUCE**: allowed; R is unaffected.

## Timing
- **Reset values** (Rst=1 at an edge): L=SEED, Cnt=MIN_VALUE, RandomValue=MIN_VALUE, Valid=0, Busy=0, state IDLE, R=0. Rst overrides Req and SeedLoad.
- **Reset mid-REDUCE**: aborts the request; no Valid is produced.
- **Counter mode latency**: Req sampled at edge n gives Valid=1 after edge n.
- **LFSR mode latency**: Req at edge n gives Busy=1 after edge n. Valid=1 and Busy=0 follow after edge n+1+k, where k = floor(raw/(SPAN+1)) ≤ 15.
- **Valid on a new LFSR request**: Valid drops to 0 after edge n of a mode-1 Req.
- **Back-to-back counter requests**: accepted every cycle.
- **Next LFSR request**: the earliest acceptance is the edge after Busy falls.
- **First counter value**: edge m after reset release leaves Cnt = MIN_VALUE+m, modulo the wrap.

## Test plan
- **Counter sample**: defaults; release Rst, Req with Mode=0 on the 5th edge after release → RandomValue=1004, Valid=1 after that edge, Busy stays 0.
- **Counter wrap**: MIN=1000, MAX=1003; Req on every edge → 1000,1001,1002,1003,1000,… with no gaps.
- **LFSR reduce**: MIN=10, MAX=13, RAND_W=4; SeedLoad Seed=16'h000F, then Req Mode=1 on the next edge (n) → Busy=1 for edges n..n+3, RandomValue=13 and Valid=1 after edge n+4.
- **Zero seed**: SeedLoad Seed=0, then Req Mode=1 next edge → sampled raw = SEED[RAND_W-1:0], identical to sampling right after reset.
- **Busy and reset**: Req during Busy → ignored, result unchanged. Rst during REDUCE → after that edge Valid=0, Busy=0, RandomValue=MIN_VALUE, L=SEED.
- **Range sweep**: defaults, 10k random Req/Mode/SeedLoad stimulus → every Valid value in [1000,6000], every LFSR-mode latency ≤ 17 edges, L never 0.

Source files
------------

// File: rtl/random_range_gen.sv
// Random value source for the reaction timer: a wrapping press-timing counter
// or a reseedable Galois LFSR folded into [MIN_VALUE, MAX_VALUE] by repeated subtraction.
module random_range_gen #(
    parameter int unsigned             WIDTH     = 13,
    parameter int unsigned             MIN_VALUE = 1000,
    parameter int unsigned             MAX_VALUE = 6000,
    parameter int unsigned             LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]       TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0]       SEED      = 16'hACE1,
    parameter int unsigned             RAND_W    = 13
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Mode,
    input  logic              Req,
    input  logic              SeedLoad,
    input  logic [LFSR_W-1:0] Seed,
    output logic              Busy,
    output logic              Valid,
    output logic [WIDTH-1:0]  RandomValue
);

    localparam int unsigned SPAN  = MAX_VALUE - MIN_VALUE;
    localparam int unsigned CMP_W = ((RAND_W > WIDTH) ? RAND_W : WIDTH) + 1;
    localparam logic [RAND_W-1:0] SUB   = RAND_W'(SPAN + 1);
    localparam logic [CMP_W-1:0]  SPAN_C = CMP_W'(SPAN);
    localparam logic [WIDTH-1:0]  MIN_W = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0]  MAX_W = WIDTH'(MAX_VALUE);

    typedef enum logic {IDLE, REDUCE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [RAND_W-1:0]   r_q, r_d;
    logic [WIDTH-1:0]    value_q, value_d;
    logic                valid_q, valid_d;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= MIN_W;
            lfsr_q  <= SEED;
            r_q     <= '0;
            value_q <= MIN_W;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            r_q     <= r_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        value_d = value_q;
        valid_d = valid_q;

        cnt_d = (cnt_q == MAX_W) ? MIN_W : cnt_q + 1'b1;

        // A zero seed is replaced by SEED so the LFSR can never lock up.
        if (SeedLoad) begin
            lfsr_d = (Seed == '0) ? SEED : Seed;
        end else begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        end

        unique case (state_q)
            IDLE: begin
                if (Req) begin
                    if (!Mode) begin
                        value_d = cnt_q;
                        valid_d = 1'b1;
                    end else begin
                        r_d     = lfsr_q[RAND_W-1:0];
                        valid_d = 1'b0;
                        state_d = REDUCE;
                    end
                end
            end
            REDUCE: begin
                if (CMP_W'(r_q) > SPAN_C) begin
                    r_d = r_q - SUB;
                end else begin
                    value_d = MIN_W + WIDTH'(r_q);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy        = (state_q == REDUCE);
        Valid       = valid_q;
        RandomValue = value_q;
    end

endmodule

// File: tb/tb_random_range_gen.sv
// Scoreboarded bench for random_range_gen: default instance under a behavioural
// model with random stimulus, plus a small-range instance for wrap and reduce timing.
module tb_random_range_gen;

    localparam int unsigned MIN_V  = 1000;
    localparam int unsigned MAX_V  = 6000;
    localparam int unsigned SPAN_V = MAX_V - MIN_V;
    localparam int unsigned RW     = 13;
    localparam logic [15:0] SEED_V = 16'hACE1;
    localparam logic [15:0] TAPS_V = 16'hB400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, mode = 1'b0, req = 1'b0, sl = 1'b0;
    logic [15:0] seed = '0;
    logic        busy, valid;
    logic [12:0] value;

    logic        s_rst = 1'b1, s_mode = 1'b0, s_req = 1'b0, s_sl = 1'b0;
    logic [15:0] s_seed = '0;
    logic        s_busy, s_valid;
    logic [12:0] s_value;

    random_range_gen dut (
        .Clk(clk), .Rst(rst), .Mode(mode), .Req(req), .SeedLoad(sl), .Seed(seed),
        .Busy(busy), .Valid(valid), .RandomValue(value)
    );

    random_range_gen #(.WIDTH(13), .MIN_VALUE(10), .MAX_VALUE(13), .RAND_W(4)) dut_s (
        .Clk(clk), .Rst(s_rst), .Mode(s_mode), .Req(s_req), .SeedLoad(s_sl), .Seed(s_seed),
        .Busy(s_busy), .Valid(s_valid), .RandomValue(s_value)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", nm, edge_n, act, expv);
        end
    endtask

    typedef struct {
        int          e;
        bit          valid;
        bit          busy;
        int unsigned value;
        logic [15:0] l;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural model state: counter as edges since reset, pending LFSR result with its due edge
    logic [15:0] m_l     = SEED_V;
    int unsigned m_steps = 0;
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int unsigned m_value = MIN_V;
    int unsigned m_pend  = 0;
    int          m_done  = 0;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ TAPS_V) : (l >> 1);
    endfunction

    task automatic cyc(input bit r, input bit q, input bit md, input bit s, input logic [15:0] sd);
        int unsigned raw;
        int e;
        @(negedge clk);
        #1;
        rst = r; req = q; mode = md; sl = s; seed = sd;
        e = edge_n + 1;
        if (r) begin
            m_l = SEED_V; m_steps = 0; m_busy = 0; m_valid = 0; m_value = MIN_V;
        end else begin
            if (m_busy) begin
                if (e == m_done) begin
                    m_busy = 0; m_valid = 1; m_value = m_pend;
                end
            end else if (q) begin
                if (!md) begin
                    m_value = MIN_V + m_steps % (SPAN_V + 1);
                    m_valid = 1;
                end else begin
                    raw    = int'(m_l) % (1 << RW);
                    m_pend = MIN_V + raw % (SPAN_V + 1);
                    m_done = e + 1 + int'(raw / (SPAN_V + 1));
                    m_busy = 1; m_valid = 0;
                end
            end
            m_l = s ? ((sd == 16'h0) ? SEED_V : sd) : lstep(m_l);
            m_steps++;
        end
        exp_q.push_back('{e, m_valid, m_busy, m_value, m_l});
    endtask

    exp_t cur;
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].e == edge_n) begin
            cur = exp_q.pop_front();
            chk("valid", longint'(valid), longint'(cur.valid));
            chk("busy", longint'(busy), longint'(cur.busy));
            chk("value", longint'(value), longint'(cur.value));
            chk("lfsr", longint'(dut.lfsr_q), longint'(cur.l));
            chk("lfsr_nonzero", longint'(dut.lfsr_q != 16'h0), 1);
            if (valid) chk("in_range", longint'(value >= 13'(MIN_V) && value <= 13'(MAX_V)), 1);
        end
    end

    initial begin
        // Small instance: MIN=10, MAX=13, RAND_W=4
        @(negedge clk);
        @(negedge clk);
        chk("s_reset_valid", longint'(s_valid), 0);
        chk("s_reset_busy", longint'(s_busy), 0);
        chk("s_reset_value", longint'(s_value), 10);
        #1;
        s_rst = 1'b0; s_req = 1'b1; s_mode = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("s_wrap_value", longint'(s_value), longint'(10 + (i - 1) % 4));
            chk("s_wrap_valid", longint'(s_valid), 1);
        end
        #1;
        s_req = 1'b0; s_sl = 1'b1; s_seed = 16'h000F;
        @(negedge clk);
        #1;
        s_sl = 1'b0; s_req = 1'b1; s_mode = 1'b1;
        @(negedge clk);
        chk("s_reduce_busy_n", longint'(s_busy), 1);
        chk("s_reduce_valid_n", longint'(s_valid), 0);
        #1;
        s_mode = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk("s_reduce_busy", longint'(s_busy), 1);
            chk("s_reduce_valid", longint'(s_valid), 0);
        end
        @(negedge clk);
        chk("s_reduce_done_busy", longint'(s_busy), 0);
        chk("s_reduce_done_valid", longint'(s_valid), 1);
        chk("s_reduce_value", longint'(s_value), 13);
        #1;
        s_req = 1'b0;

        // Default instance: directed cases through the scoreboard
        cyc(1, 0, 0, 0, 16'h0);
        repeat (4) cyc(0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 16'h0);
        cyc(0, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 1, 16'h0);
        cyc(0, 1, 1, 0, 16'h0);
        repeat (3) cyc(0, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        cyc(0, 1, 1, 0, 16'h0);
        repeat (3) cyc(0, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 1, 16'h1F40);
        cyc(0, 1, 1, 0, 16'h0);
        cyc(0, 1, 0, 0, 16'h0);
        cyc(0, 1, 1, 0, 16'h0);
        repeat (3) cyc(0, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 1, 16'h1F40);
        cyc(0, 1, 1, 0, 16'h0);
        cyc(1, 1, 1, 1, 16'h1234);
        repeat (2) cyc(0, 0, 0, 0, 16'h0);
        cyc(0, 1, 1, 1, 16'h0);
        repeat (3) cyc(0, 0, 0, 0, 16'h0);

        for (int k = 0; k < 10000; k++) begin
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        end
        repeat (20) cyc(0, 0, 0, 0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
